// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the output-port UART transmitter
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int FRAME_BITS     = 10;
  localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered storage and explicit occupancy counter
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// rtl/out_port_uart_tx.sv - queues CPU output-port words and sends each as two 8N1 frames, low byte first
module out_port_uart_tx
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DATA_W-1:0]             out_port_i,
  input  logic                          out_we_i,
  input  logic                          ovf_clr_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o
);

  localparam int BYTE_W = DATA_W / BYTES_PER_WORD;

  tx_state_t         state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] hi_byte_q, hi_byte_d;
  logic              byte_sel_q, byte_sel_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [15:0]       baud_cnt_q, baud_cnt_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] fifo_word;
  logic              fifo_full, fifo_empty, fifo_pop, bit_done, drop;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (out_we_i),
    .pop_i   (fifo_pop),
    .wdata_i (out_port_i),
    .rdata_o (fifo_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign drop     = out_we_i && fifo_full && !fifo_pop;
  assign bit_done = (baud_cnt_q == 16'(CLKS_PER_BIT - 1));

  assign tx_o       = tx_q;
  assign busy_o     = (state_q != IDLE) || !fifo_empty;
  assign overflow_o = overflow_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hi_byte_d  = hi_byte_q;
    byte_sel_d = byte_sel_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = bit_done ? 16'd0 : baud_cnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        baud_cnt_d = 16'd0;
        if (!fifo_empty) begin
          shift_d    = fifo_word[BYTE_W-1:0];
          hi_byte_d  = fifo_word[DATA_W-1:BYTE_W];
          byte_sel_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[BYTE_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // The high byte follows its low byte with no idle gap.
        if (bit_done) begin
          if (!byte_sel_q) begin
            shift_d    = hi_byte_q;
            byte_sel_d = 1'b1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line lines up with the state it describes.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    overflow_d = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      hi_byte_q  <= '0;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      hi_byte_q  <= hi_byte_d;
      byte_sel_q <= byte_sel_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
